// File: rtl/lcd_digit_driver.sv
// lcd_digit_driver: HD44780 write-only controller that shows "A:dd B:dd C:dd" on line 1
//   clock_50 / reset_n : clock (rising edge), asynchronous active-low reset
//   tens_* / ones_*    : BCD tens/ones digits for values A, B and C
//   LCD_*              : DE2 character LCD pins, all waits counter-timed (busy flag never read)
//   init_done          : high once the init command sequence has completed
//   frame_done         : one-cycle pulse at the end of each refresh frame
module lcd_digit_driver #(
   parameter int POWER_UP_CYCLES   = 750000,
   parameter int EN_CYCLES         = 25,
   parameter int WAIT_CYCLES       = 2500,
   parameter int CLEAR_WAIT_CYCLES = 100000
) (
   input  logic       clock_50,
   input  logic       reset_n,
   input  logic [3:0] tens_a,
   input  logic [3:0] ones_a,
   input  logic [3:0] tens_b,
   input  logic [3:0] ones_b,
   input  logic [3:0] tens_c,
   input  logic [3:0] ones_c,
   output logic       LCD_ON,
   output logic       LCD_BLON,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic [7:0] LCD_DATA,
   output logic       init_done,
   output logic       frame_done
);
   localparam int M1   = (POWER_UP_CYCLES > CLEAR_WAIT_CYCLES) ? POWER_UP_CYCLES : CLEAR_WAIT_CYCLES;
   localparam int M2   = (EN_CYCLES > WAIT_CYCLES) ? EN_CYCLES : WAIT_CYCLES;
   localparam int MAXC = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] P_LAST = CW'(POWER_UP_CYCLES - 1);
   localparam logic [CW-1:0] E_LAST = CW'(EN_CYCLES - 1);
   localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CLEAR_WAIT_CYCLES - 1);

   typedef enum logic [1:0] {POWER, INIT, ADDR, CHAR} state_t;
   typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

   state_t        state_q, state_d;
   phase_t        phase_q, phase_d;
   logic [3:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   snap_q, snap_d;
   logic          init_done_q, init_done_d;
   logic          frame_done_q, frame_done_d;
   logic [7:0]    byte_s;
   logic [CW-1:0] last_s;
   logic          done_s;

   // Invalid BCD (10..15) is shown as '-'
   function automatic logic [7:0] enc(input logic [3:0] d);
      return (d > 4'd9) ? 8'h2D : {4'h3, d};
   endfunction

   always_comb begin
      byte_s = 8'h00;
      case (state_q)
         INIT: byte_s = (idx_q == 4'd0) ? 8'h38 : (idx_q == 4'd1) ? 8'h0C :
                        (idx_q == 4'd2) ? 8'h01 : 8'h06;
         ADDR: byte_s = 8'h80;
         CHAR:
            case (idx_q)
               4'd0:    byte_s = 8'h41;
               4'd1:    byte_s = 8'h3A;
               4'd2:    byte_s = enc(snap_q[23:20]);
               4'd3:    byte_s = enc(snap_q[19:16]);
               4'd5:    byte_s = 8'h42;
               4'd6:    byte_s = 8'h3A;
               4'd7:    byte_s = enc(snap_q[15:12]);
               4'd8:    byte_s = enc(snap_q[11:8]);
               4'd10:   byte_s = 8'h43;
               4'd11:   byte_s = 8'h3A;
               4'd12:   byte_s = enc(snap_q[7:4]);
               4'd13:   byte_s = enc(snap_q[3:0]);
               default: byte_s = 8'h20;
            endcase
         default: byte_s = 8'h00;
      endcase
   end

   // Terminal count of the current phase; only the clear command (INIT index 2) gets the long hold
   assign last_s = (state_q == POWER) ? P_LAST :
                   (phase_q == PULSE) ? E_LAST :
                   (state_q == INIT && idx_q == 4'd2) ? C_LAST : W_LAST;
   assign done_s = (cnt_q == last_s);

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q + 1'b1;
      snap_d       = snap_q;
      init_done_d  = init_done_q;
      frame_done_d = 1'b0;
      if (state_q == POWER) begin
         if (done_s) begin
            state_d = INIT;
            phase_d = SETUP;
            idx_d   = 4'd0;
            cnt_d   = '0;
         end
      end else if (phase_q == SETUP) begin
         phase_d = PULSE;
         cnt_d   = '0;
      end else if (phase_q == PULSE) begin
         if (done_s) begin
            phase_d = HOLD;
            cnt_d   = '0;
         end
      end else if (done_s) begin
         phase_d = SETUP;
         cnt_d   = '0;
         idx_d   = idx_q + 4'd1;
         if (state_q == INIT && idx_q == 4'd3) begin
            state_d     = ADDR;
            idx_d       = 4'd0;
            init_done_d = 1'b1;
            snap_d      = {tens_a, ones_a, tens_b, ones_b, tens_c, ones_c};
         end else if (state_q == ADDR) begin
            state_d = CHAR;
            idx_d   = 4'd0;
         end else if (state_q == CHAR && idx_q == 4'd13) begin
            state_d      = ADDR;
            idx_d        = 4'd0;
            frame_done_d = 1'b1;
            snap_d       = {tens_a, ones_a, tens_b, ones_b, tens_c, ones_c};
         end
      end
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= POWER;
         phase_q      <= SETUP;
         idx_q        <= 4'd0;
         cnt_q        <= '0;
         snap_q       <= '0;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         snap_q       <= snap_d;
         init_done_q  <= init_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   // EN decodes straight from the phase register so an asynchronous reset drops it at once
   assign LCD_EN     = (phase_q == PULSE);
   assign LCD_RS     = (state_q == CHAR);
   assign LCD_DATA   = byte_s;
   assign LCD_ON     = 1'b1;
   assign LCD_BLON   = 1'b1;
   assign LCD_RW     = 1'b0;
   assign init_done  = init_done_q;
   assign frame_done = frame_done_q;
endmodule

// File: doc/lcd_digit_driver.md
Name: lcd_digit_driver

Overview:
- Sequential HD44780-style character LCD write controller on the DE2 LCD pins.
- Consumes three two-digit BCD values, i.e. the tens/ones digit outputs of the BCD converters.
- Runs the power-up/init command sequence once, then continuously refreshes line 1 with the text "A:dd B:dd C:dd".
- Write-only; it never reads the LCD busy flag. All waits are counter-timed.

Parameters:
- POWER_UP_CYCLES, 750000: idle cycles after reset before the first command (15 ms at 50 MHz).
- EN_CYCLES, 25: cycles LCD_EN is held high per byte (500 ns).
- WAIT_CYCLES, 2500: cycles LCD_EN is held low after each byte (50 us).
- CLEAR_WAIT_CYCLES, 100000: post-pulse wait used only after the clear command 0x01 (2 ms).

Ports:
- clock_50  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tens_a  input  4  BCD tens digit, value A.
- ones_a  input  4  BCD ones digit, value A.
- tens_b  input  4  BCD tens digit, value B.
- ones_b  input  4  BCD ones digit, value B.
- tens_c  input  4  BCD tens digit, value C.
- ones_c  input  4  BCD ones digit, value C.
- LCD_ON  output  1  LCD power; constant 1.
- LCD_BLON  output  1  backlight; constant 1.
- LCD_RW  output  1  constant 0 (write).
- LCD_EN  output  1  enable strobe.
- LCD_RS  output  1  0 = command, 1 = character data.
- LCD_DATA  output  8  command or character byte.
- init_done  output  1  high once the init sequence has completed.
- frame_done  output  1  one-cycle pulse at the end of each refresh frame.

Behaviour:
- Reset (asynchronous, while reset_n = 0):
  - LCD_EN = 0, LCD_RS = 0, LCD_DATA = 8'h00, init_done = 0, frame_done = 0.
  - LCD_ON = 1, LCD_BLON = 1, LCD_RW = 0.
  - State = POWER, all counters = 0.
- Reset asserted mid-byte: LCD_EN drops immediately (asynchronously). After release the whole sequence restarts from POWER.
- Byte transfer takes SETUP + PULSE + HOLD:
  - SETUP: 1 cycle. RS and DATA driven, EN = 0.
  - PULSE: EN_CYCLES cycles with EN = 1.
  - HOLD: WAIT_CYCLES cycles with EN = 0 (CLEAR_WAIT_CYCLES for byte 0x01).
  - RS and DATA stay stable across all three phases.
  - Total = 1 + EN_CYCLES + wait cycles.
- State machine:
  - POWER: count POWER_UP_CYCLES, then go to INIT.
  - INIT: send commands 0x38, 0x0C, 0x01, 0x06 in order with RS = 0. After the HOLD of 0x06, set init_done = 1 (stays 1 until reset) and go to ADDR.
  - ADDR: snapshot all six digit inputs into internal registers in the cycle ADDR is entered. Send 0x80 (line 1, column 0) with RS = 0, then go to CHAR.
  - CHAR: send 14 bytes with RS = 1, index 0..13, in this order:
    - 'A' (0x41), ':' (0x3A), tA, oA, space (0x20)
    - 'B' (0x42), ':', tB, oB, space
    - 'C' (0x43), ':', tC, oC
    - After the HOLD of index 13: frame_done = 1 for one cycle, and the next cycle enters ADDR (the next frame).
- Digit encoding:
  - Digit values 0..9 map to 8'h30 + digit.
  - Values 10..15 (invalid BCD) map to '-' (0x2D).
- Digit input changes mid-frame do not affect the current frame. They appear in the next frame via the snapshot.
- Timing with default-style parameters E = EN_CYCLES, W = WAIT_CYCLES:
  - Frame length = 15 × (1 + E + W) cycles.
  - Init length = 4 + 4E + 3W + CLEAR_WAIT_CYCLES cycles.
- Counters are sized for the largest parameter. Counters never wrap during a phase; each one reloads at every phase change.

Test Plan (POWER_UP_CYCLES=20, EN_CYCLES=3, WAIT_CYCLES=5, CLEAR_WAIT_CYCLES=10; cycle 0 = first clock_50 edge after reset_n rises):
- Reset values: hold reset_n = 0 → EN=0, RS=0, DATA=00, RW=0, ON=1, BLON=1, init_done=0.
- Init sequence: release reset → EN pulses 3 cycles wide carrying 38, 0C, 01, 06 with RS=0. Gap after 01 is 10 cycles; the other gaps are 5. init_done rises after the 06 hold.
- Frame content: digits A=4,2; B=0,9; C=7,7 → after 80, RS=1 bytes are 41 3A 34 32 20 42 3A 30 39 20 43 3A 37 37. frame_done pulses once, 135 cycles after 80's SETUP cycle.
- Invalid BCD: ones_b = 4'hC → byte at index 8 = 2D.
- Snapshot: change tens_a from 4 to 5 during CHAR index 5 → the current frame still shows 34 at index 2; the next frame shows 35.
- Reset mid-pulse: assert reset_n = 0 while EN = 1 in a CHAR byte → EN falls with no clock edge. After release, EN stays 0 for the 20-cycle POWER wait, then 38 is sent again.
